// File: rtl/inst_loader.sv
// inst_loader: receives a program over a UART byte stream and writes it into
// the instruction BRAM, then acknowledges the host and releases the core.
//
// Stream format: a 4-byte little-endian word count N, then N words, each
// sent as 4 bytes little-endian. Oversize programs (N > 2**ADDR_W) latch a
// sticky error.
//
// Ports
//   clk, rstn           clock, async active-low reset
//   rx_data/rx_valid    received byte + one-cycle strobe (no backpressure)
//   tx_data/tx_valid    ack byte + request, accepted when tx_ready is high
//   tx_ready            transmitter ready
//   wea/addra/dina      BRAM write port (one-cycle strobe per word)
//   mode                core mode: 0 STALL, 1 LOAD, 2 EXEC
//   done                program loaded and acknowledged
//   err                 sticky oversize-program error
module inst_loader #(
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic [2:0]        mode,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_ACK, S_RUN, S_ERR} state_t;

  localparam logic [2:0] M_STALL = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_EXEC  = 3'd2;

  state_t            state, state_nxt;
  logic [1:0]        lane;
  logic [23:0]       sh;      // lower three bytes of the word being assembled
  logic [31:0]       n;
  logic [ADDR_W-1:0] widx;

  logic [31:0] word;
  logic        byte_in, word_done, last_wr, oversize;

  // Bytes only matter while collecting a header or payload.
  assign byte_in   = rx_valid && (state == S_HDR || state == S_LOAD);
  assign word      = {rx_data, sh};
  assign word_done = byte_in && (lane == 2'd3);

  // Full-width unsigned compares so large N never aliases into range.
  assign oversize = 33'(word) > (33'd1 << ADDR_W);
  // The write strobe of word N-1 is what ends the load; leaving LOAD only
  // after that strobe keeps wea confined to LOAD and avoids a wrap write.
  assign last_wr  = wea && (32'(addra) == n - 32'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:  if (word_done) begin
                if (word == 32'd0)  state_nxt = S_ACK;
                else if (oversize)  state_nxt = S_ERR;
                else                state_nxt = S_LOAD;
              end
      S_LOAD: if (last_wr) state_nxt = S_ACK;
      S_ACK:  if (tx_valid && tx_ready) state_nxt = S_RUN;
      default: state_nxt = state;   // RUN and ERR hold until reset
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_HDR;
      lane     <= '0;
      sh       <= '0;
      n        <= '0;
      widx     <= '0;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      mode     <= M_STALL;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state <= state_nxt;

      if (byte_in) begin
        lane <= lane + 2'd1;   // wraps 3->0 at each word/header boundary
        case (lane)
          2'd0: sh[7:0]   <= rx_data;
          2'd1: sh[15:8]  <= rx_data;
          2'd2: sh[23:16] <= rx_data;
          default: if (state == S_HDR) n <= word;
        endcase
      end

      wea <= word_done && (state == S_LOAD);
      if (word_done && state == S_LOAD) begin
        addra <= widx;
        dina  <= word;
        widx  <= widx + 1'b1;
      end

      // Outputs follow the state being entered so they stay registered.
      tx_valid <= (state_nxt == S_ACK);
      if (state_nxt == S_ACK) tx_data <= ACK_BYTE;
      done <= (state_nxt == S_RUN);
      err  <= (state_nxt == S_ERR);
      case (state_nxt)
        S_LOAD, S_ACK: mode <= M_LOAD;
        S_RUN:         mode <= M_EXEC;
        default:       mode <= M_STALL;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic [2:0]        mode;
  logic              done;
  logic              err;

  inst_loader #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wea(wea), .addra(addra), .dina(dina), .mode(mode), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscnt  = 0;
  int gap     = 1;     // idle cycles after each byte (0 = back-to-back)

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                tx_cnt = 0;
  logic [7:0]        tx_last = '0;

  // Write / handshake logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (wea) begin
        wr_addr.push_back(addra);
        wr_data.push_back(dina);
      end
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        tx_last = tx_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // All byte tasks start and end just after a rising edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    gap      = 1;
    wr_addr.delete();
    wr_data.delete();
    tx_cnt   = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (!done && !err && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(k < budget), 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] big_word(input int i);
    return {i[15:0] ^ 16'hBEEF, i[15:0]};
  endfunction

  initial begin
    // ---------------- reset values while rstn low
    #13;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err), 32'd0);
    chk("rst_wea",  32'(wea), 32'd0);
    chk("rst_addra",32'(addra), 32'd0);
    chk("rst_dina", dina, 32'd0);
    chk("rst_txv",  32'(tx_valid), 32'd0);
    chk("rst_txd",  32'(tx_data), 32'd0);
    do_reset();

    // ---------------- two-word load
    send_word(32'd2);
    chk("hdr_mode", 32'(mode), 32'd1);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    wait_end("two_timeout", 50);
    chk("two_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("two_a0", 32'(wr_addr[0]), 32'd0);
      chk("two_d0", wr_data[0], 32'h12345678);
      chk("two_a1", 32'(wr_addr[1]), 32'd1);
      chk("two_d1", wr_data[1], 32'hDEADBEEF);
    end
    chk("two_tx", 32'(tx_cnt), 32'd1);
    chk("two_txd", 32'(tx_last), 32'hAA);
    chk("two_mode", 32'(mode), 32'd2);
    chk("two_done", 32'(done), 32'd1);
    chk("two_txv", 32'(tx_valid), 32'd0);

    // ---------------- zero-length program
    do_reset();
    send_word(32'd0);
    wait_end("zero_timeout", 50);
    chk("zero_nwr", 32'(wr_addr.size()), 32'd0);
    chk("zero_tx", 32'(tx_cnt), 32'd1);
    chk("zero_mode", 32'(mode), 32'd2);

    // ---------------- ack backpressure
    do_reset();
    tx_ready = 1'b0;
    send_word(32'd1);
    send_word(32'hA5A5_0F0F);
    begin
      int k = 0;
      int stable = 1;
      while (!tx_valid && k < 50) begin @(negedge clk); k++; end
      chk("bp_txv_timeout", 32'(k < 50), 32'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!(tx_valid === 1'b1 && tx_data === 8'hAA && mode === 3'd1 && done === 1'b0))
          stable = 0;
      end
      chk("bp_hold", 32'(stable), 32'd1);
      @(posedge clk); #1 tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_txv", 32'(tx_valid), 32'd1);
      @(negedge clk);
      chk("bp_post_txv", 32'(tx_valid), 32'd0);
      chk("bp_post_done", 32'(done), 32'd1);
      chk("bp_tx", 32'(tx_cnt), 32'd1);
      chk("bp_wr", (wr_data.size() == 1) ? wr_data[0] : 32'hX, 32'hA5A50F0F);
    end

    // ---------------- oversize program
    do_reset();
    send_word(32'd4097);
    repeat (3) @(negedge clk);
    chk("ovr_err", 32'(err), 32'd1);
    chk("ovr_mode", 32'(mode), 32'd0);
    chk("ovr_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    send_word(32'h11223344);
    send_word(32'h55667788);
    chk("ovr_nwr", 32'(wr_addr.size()), 32'd0);
    chk("ovr_sticky", 32'(err), 32'd1);
    chk("ovr_txv", 32'(tx_valid), 32'd0);

    // ---------------- full-depth program, back-to-back bytes
    do_reset();
    gap = 0;
    send_word(32'd4096);
    for (int i = 0; i < 4096; i++) send_word(big_word(i));
    wait_end("big_timeout", 50);
    chk("big_nwr", 32'(wr_addr.size()), 32'd4096);
    begin
      int bad = 0;
      for (int i = 0; i < wr_addr.size(); i++)
        if (wr_addr[i] !== i[ADDR_W-1:0] || wr_data[i] !== big_word(i)) bad++;
      chk("big_seq", 32'(bad), 32'd0);
    end
    chk("big_last", (wr_addr.size() > 0) ? 32'(wr_addr[$]) : 32'hX, 32'hFFF);
    chk("big_done", 32'(done), 32'd1);

    // ---------------- extra bytes in RUN are ignored
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0001);
    repeat (2) @(negedge clk);
    chk("run_nwr", 32'(wr_addr.size()), 32'd4096);
    chk("run_done", 32'(done), 32'd1);
    chk("run_mode", 32'(mode), 32'd2);
    chk("run_tx", 32'(tx_cnt), 32'd1);
    @(posedge clk); #1;

    // ---------------- reset mid-load
    do_reset();
    send_word(32'd2);
    send_word(32'h0BAD_0BAD);
    send(8'h77);
    rstn = 1'b0;
    #1;
    chk("mid_mode", 32'(mode), 32'd0);
    chk("mid_wea", 32'(wea), 32'd0);
    chk("mid_addra", 32'(addra), 32'd0);
    chk("mid_dina", dina, 32'd0);
    chk("mid_txv", 32'(tx_valid), 32'd0);
    do_reset();
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_end("mid_timeout", 50);
    chk("mid_nwr", 32'(wr_addr.size()), 32'd1);
    chk("mid_a", (wr_addr.size() > 0) ? 32'(wr_addr[0]) : 32'hX, 32'd0);
    chk("mid_d", (wr_data.size() > 0) ? wr_data[0] : 32'hX, 32'hCAFEF00D);
    chk("mid_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscnt);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL be the instruction-memory word-address width; depth is 2**ADDR_W words.
REQ-002 Parameter ACK_BYTE, default 8'hAA, SHALL be the byte sent to the host when a load completes.
REQ-003 Reset is asynchronous and active-low, and the block uses one clock.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rstn, input, 1: asynchronous active-low reset.
REQ-006 Port rx_data, input, 8: received UART byte; valid only while rx_valid is high.
REQ-007 Port rx_valid, input, 1: one-cycle strobe per received byte; there is no backpressure.
REQ-008 Port tx_data, output, 8: byte to transmit.
REQ-009 Port tx_valid, output, 1: transmit request.
REQ-010 Port tx_ready, input, 1: the transmitter accepts tx_data in any cycle where tx_valid and tx_ready are both high.
REQ-011 Port wea, output, 1: one-cycle write strobe to the instruction BRAM.
REQ-012 Port addra, output, ADDR_W: BRAM word address.
REQ-013 Port dina, output, 32: BRAM write data.
REQ-014 Port mode, output, 3: core mode, with STALL=0, LOAD=1 and EXEC=2.
REQ-015 Port done, output, 1: high once the program is loaded and acknowledged.
REQ-016 Port err, output, 1: sticky error indicating an oversize program.

Function
REQ-017 States SHALL be HDR, LOAD, ACK, RUN and ERR.
REQ-018 HDR SHALL collect 4 bytes as word count N, little-endian (first byte is bits 7:0).
REQ-019 On the 4th header byte, the next state SHALL be as follows.
- N==0: ACK.
- N > 2**ADDR_W: ERR.
- Otherwise: LOAD.
REQ-020 LOAD SHALL assemble each group of 4 bytes little-endian into a 32-bit word.
REQ-021 One cycle after the rx_valid of each group's 4th byte, wea SHALL be 1 for exactly one cycle, with addra equal to the word index (0..N-1) and dina equal to the assembled word.
REQ-022 The word index SHALL increment after each write; a byte arriving in the same cycle as wea SHALL still be captured.
REQ-023 After the write of word N-1, the state SHALL be ACK; N == 2**ADDR_W SHALL be legal, with last addra = all ones and no wrap-around write.
REQ-024 ACK: tx_valid=1 and tx_data=ACK_BYTE SHALL be held until the handshake cycle (tx_valid and tx_ready both high); tx_valid SHALL then be 0 and the next state SHALL be RUN.
REQ-025 tx_valid SHALL NOT be asserted in any state other than ACK.
REQ-026 RUN SHALL be terminal until reset, with done=1 and mode=EXEC.
REQ-027 ERR SHALL be terminal until reset, with err=1, mode=STALL and done=0.
REQ-028 mode SHALL be STALL in HDR and ERR, LOAD in LOAD and ACK, and EXEC in RUN.
REQ-029 In ACK, RUN and ERR, rx bytes SHALL be ignored and SHALL NOT cause writes or state change.
REQ-030 wea SHALL be 0 outside LOAD, and at most one write SHALL occur per cycle.
REQ-031 The byte-lane counter (2 bits) SHALL wrap 3->0 on each completed word or header.
REQ-032 The internal count N SHALL be 32 bits wide, and the comparison SHALL be unsigned at full width; truncated compares are not permitted.
REQ-033 All outputs SHALL be registered, with no combinational path from input to output except none required.

Reset
REQ-034 While rstn is 0, the block SHALL be asynchronously in state HDR with the following output values.
- mode=STALL.
- done=0.
- err=0.
- wea=0.
- addra=0.
- dina=0.
- tx_valid=0.
- tx_data=0.
REQ-035 Byte lane, word index and N SHALL be cleared on reset.
REQ-036 Reset asserted mid-LOAD or mid-ACK SHALL abort the operation, and a fresh header SHALL be required after release.
REQ-037 No write SHALL be issued in the cycle rstn deasserts.

Verification
REQ-038 Scenario: header 02 00 00 00, then 78 56 34 12 EF BE AD DE -> writes (0, 0x12345678) and (1, 0xDEADBEEF), each wea one cycle; then tx 0xAA, then mode=2 and done=1.
REQ-039 Scenario: header 00 00 00 00 -> no wea, tx 0xAA, then RUN.
REQ-040 Scenario: with ADDR_W=12, header 01 10 00 00 (N=4097) -> ERR with err=1, mode=0 and no writes; a header with N=4096 -> last write at addra=0xFFF, then ACK.
REQ-041 Scenario: in ACK, hold tx_ready=0 for 10 cycles -> tx_valid stays 1 with tx_data stable; assert tx_ready -> tx_valid drops the next cycle and done=1.
REQ-042 Scenario: pull rstn low after the 5th payload byte -> all outputs reset immediately; a new 1-word load then writes at addra=0 with the new data.
REQ-043 Scenario: rx_valid on consecutive cycles (back-to-back bytes), and extra bytes sent in RUN -> correct words written, and extra bytes produce no wea and no state change.
